// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/sequencer for the single-port data memory / IO bus.
// Optional alignment check enabled by defining ARB_ALIGN_CHECK_EN.
module mem_bus_arbiter #(
   parameter int RR_EN = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic             m0_req,
   input  logic [31:0]      m0_addr,
   input  logic [31:0]      m0_wdata,
   input  logic             m0_we,
   output logic             m0_gnt,
   output logic             m0_rvalid,
   output logic [31:0]      m0_rdata,
   input  logic             m1_req,
   input  logic [31:0]      m1_addr,
   input  logic [31:0]      m1_wdata,
   input  logic             m1_we,
   output logic             m1_gnt,
   output logic             m1_rvalid,
   output logic [31:0]      m1_rdata,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_we,
   input  logic [31:0]      mem_rdata,
   output logic             arb_err,
   output logic [CNT_W-1:0] arb_conflict_cnt
);

`ifdef ARB_ALIGN_CHECK_EN
   typedef enum logic [1:0] {IDLE, BUS, RESP, ERR} state_t;
`else
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
`endif

   state_t           state_reg, state_next;
   logic [31:0]      addr_reg, wdata_reg;
   logic             we_reg, owner_reg, last_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic             tie, any_req, win1;
   logic [31:0]      sel_addr, sel_wdata;
   logic             sel_we;

   // Winner selection; last_reg=1 after reset so m0 takes the first round-robin tie.
   always_comb begin
      tie     = m0_req & m1_req;
      any_req = m0_req | m1_req;
      if (tie)
         win1 = (RR_EN != 0) ? ~last_reg : 1'b1;
      else
         win1 = m1_req;
      sel_addr  = win1 ? m1_addr  : m0_addr;
      sel_wdata = win1 ? m1_wdata : m0_wdata;
      sel_we    = win1 ? m1_we    : m0_we;
   end

   // mem_we is decoded from state so an asynchronous reset drops it immediately.
   always_comb begin
      state_next = state_reg;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      m0_rdata   = '0;
      m1_rdata   = '0;
      mem_we     = 1'b0;
      arb_err    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               m0_gnt = ~win1;
               m1_gnt = win1;
`ifdef ARB_ALIGN_CHECK_EN
               state_next = (sel_addr[1:0] != 2'b00) ? ERR : BUS;
`else
               state_next = BUS;
`endif
            end
         end
         BUS: begin
            mem_we     = we_reg;
            state_next = we_reg ? IDLE : RESP;
         end
         RESP: begin
            m0_rvalid  = ~owner_reg;
            m1_rvalid  = owner_reg;
            m0_rdata   = owner_reg ? 32'h0 : mem_rdata;
            m1_rdata   = owner_reg ? mem_rdata : 32'h0;
            state_next = IDLE;
         end
`ifdef ARB_ALIGN_CHECK_EN
         ERR: begin
            arb_err    = 1'b1;
            m0_rvalid  = ~we_reg & ~owner_reg;
            m1_rvalid  = ~we_reg & owner_reg;
            state_next = IDLE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         wdata_reg <= '0;
         we_reg    <= 1'b0;
         owner_reg <= 1'b0;
         last_reg  <= 1'b1;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && any_req) begin
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            we_reg    <= sel_we;
            owner_reg <= win1;
            last_reg  <= win1;
         end
         if (state_reg == IDLE && tie && cnt_reg != {CNT_W{1'b1}})
            cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign mem_addr         = addr_reg;
   assign mem_wdata        = wdata_reg;
   assign arb_conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance (CNT_W=16) and a fixed-priority
// instance (CNT_W=4, so counter saturation is reachable quickly) share one stimulus.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, mem_rdata = 0;

   logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_err;
   logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
   logic [15:0] a_cnt;
   logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_err;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_cnt;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.RR_EN(1), .CNT_W(16)) u_rr (
      .clk(clk), .sys_rst_n(sys_rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
      .mem_rdata(mem_rdata), .arb_err(a_err), .arb_conflict_cnt(a_cnt));

   mem_bus_arbiter #(.RR_EN(0), .CNT_W(4)) u_fp (
      .clk(clk), .sys_rst_n(sys_rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
      .mem_rdata(mem_rdata), .arb_err(b_err), .arb_conflict_cnt(b_cnt));

   // sel chooses which instance the checks observe
   logic        sel = 1'b0;
   logic        o_g0, o_g1, o_v0, o_v1, o_we, o_err;
   logic [31:0] o_rd0, o_rd1, o_addr, o_wdata;
   logic [15:0] o_cnt;
   assign o_g0    = sel ? b_m0_gnt    : a_m0_gnt;
   assign o_g1    = sel ? b_m1_gnt    : a_m1_gnt;
   assign o_v0    = sel ? b_m0_rvalid : a_m0_rvalid;
   assign o_v1    = sel ? b_m1_rvalid : a_m1_rvalid;
   assign o_rd0   = sel ? b_m0_rdata  : a_m0_rdata;
   assign o_rd1   = sel ? b_m1_rdata  : a_m1_rdata;
   assign o_addr  = sel ? b_mem_addr  : a_mem_addr;
   assign o_wdata = sel ? b_mem_wdata : a_mem_wdata;
   assign o_we    = sel ? b_mem_we    : a_mem_we;
   assign o_err   = sel ? b_err       : a_err;
   assign o_cnt   = sel ? {12'h000, b_cnt} : a_cnt;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else
         $display("[TB] ok %s = %h", name, act);
   endtask

   typedef struct {
      logic r0; logic [31:0] a0; logic we0; logic [31:0] d0;
      logic r1; logic [31:0] a1; logic we1; logic [31:0] d1;
      logic [31:0] rd;
      logic g0, g1, v0, v1;
      logic [31:0] rd0, rd1, maddr, mwdata;
      logic mwe, err;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(
      input logic r0, input logic [31:0] a0, input logic we0, input logic [31:0] d0,
      input logic r1, input logic [31:0] a1, input logic we1, input logic [31:0] d1,
      input logic [31:0] rd, input logic g0, input logic g1, input logic v0, input logic v1,
      input logic [31:0] rd0, input logic [31:0] rd1, input logic [31:0] maddr,
      input logic [31:0] mwdata, input logic mwe, input logic err, input logic [15:0] cnt);
      vec_t v;
      v.r0 = r0; v.a0 = a0; v.we0 = we0; v.d0 = d0;
      v.r1 = r1; v.a1 = a1; v.we1 = we1; v.d1 = d1; v.rd = rd;
      v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd0 = rd0; v.rd1 = rd1;
      v.maddr = maddr; v.mwdata = mwdata; v.mwe = mwe; v.err = err; v.cnt = cnt;
      return v;
   endfunction

   task automatic drive_idle();
      m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
      m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0; mem_rdata = 0;
   endtask

   task automatic do_reset(input bit check_vals);
      drive_idle();
      sys_rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (check_vals) begin
         chk("rst_gnt_rvalid", {28'h0, o_g0, o_g1, o_v0, o_v1}, 32'h0);
         chk("rst_mem_addr", o_addr, 32'h0);
         chk("rst_mem_wdata", o_wdata, 32'h0);
         chk("rst_mem_we_err", {30'h0, o_we, o_err}, 32'h0);
         chk("rst_cnt", {16'h0, o_cnt}, 32'h0);
      end
      sys_rst_n = 1'b1;
   endtask

   // Both masters hold read requests until their pending count is used up.
   task automatic run_ties(input int n0, input int n1, input bit chk_ord,
                           input logic [31:0] exp_ord, input logic [15:0] exp_cnt);
      int p0 = n0;
      int p1 = n1;
      int cyc = 0;
      int ngnt = 0;
      int dual = 0;
      logic [31:0] ord = 0;
      while ((p0 > 0 || p1 > 0) && cyc < 2000) begin
         @(posedge clk); #1;
         m0_req = (p0 > 0); m0_we = 0; m0_addr = 32'h100 + 32'(4 * (n0 - p0));
         m1_req = (p1 > 0); m1_we = 0; m1_addr = 32'h200 + 32'(4 * (n1 - p1));
         @(negedge clk);
         if (o_g0 && o_g1) dual++;
         if (o_g0) begin p0--; ngnt++; ord = (ord << 4) | 32'h0; end
         if (o_g1) begin p1--; ngnt++; ord = (ord << 4) | 32'h1; end
         cyc++;
      end
      if (p0 > 0 || p1 > 0) chk("ties_timeout", 32'h1, 32'h0);
      @(posedge clk); #1;
      drive_idle();
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("ties_gnt_total", 32'(ngnt), 32'(n0 + n1));
      chk("ties_no_dual_gnt", 32'(dual), 32'h0);
      if (chk_ord) chk("ties_order", ord, exp_ord);
      chk("ties_conflict_cnt", {16'h0, o_cnt}, {16'h0, exp_cnt});
   endtask

   vec_t vecs[17];

   initial begin
      vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  0,0,0,0, 0, 0, 0, 0, 0,0, 0);
      vecs[1]  = mk(1, 32'h10, 0, 0,  0, 0, 0, 0,  0,  1,0,0,0, 0, 0, 0, 0, 0,0, 0);
      vecs[2]  = mk(0, 0, 0, 0,  1, 32'hffff_ff00, 1, 32'hA5A5_00FF,  0,
                    0,0,0,0, 0, 0, 32'h10, 0, 0,0, 0);
      vecs[3]  = mk(0, 0, 0, 0,  1, 32'hffff_ff00, 1, 32'hA5A5_00FF,  32'h1122_3344,
                    0,0,1,0, 32'h1122_3344, 0, 32'h10, 0, 0,0, 0);
      vecs[4]  = mk(0, 0, 0, 0,  1, 32'hffff_ff00, 1, 32'hA5A5_00FF,  0,
                    0,1,0,0, 0, 0, 32'h10, 0, 0,0, 0);
      vecs[5]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,
                    0,0,0,0, 0, 0, 32'hffff_ff00, 32'hA5A5_00FF, 1,0, 0);
      vecs[6]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  32'hdead_beef,
                    0,0,0,0, 0, 0, 32'hffff_ff00, 32'hA5A5_00FF, 0,0, 0);
      vecs[7]  = mk(0, 0, 0, 0,  1, 32'h6, 0, 0,  0,
                    0,1,0,0, 0, 0, 32'hffff_ff00, 32'hA5A5_00FF, 0,0, 0);
`ifdef ARB_ALIGN_CHECK_EN
      vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  32'h5566_7788,
                    0,0,0,1, 0, 0, 32'h6, 0, 0,1, 0);
      vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  32'h5566_7788,
                    0,0,0,0, 0, 0, 32'h6, 0, 0,0, 0);
`else
      vecs[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  32'h5566_7788,
                    0,0,0,0, 0, 0, 32'h6, 0, 0,0, 0);
      vecs[9]  = mk(0, 0, 0, 0,  0, 0, 0, 0,  32'h5566_7788,
                    0,0,0,1, 0, 32'h5566_7788, 32'h6, 0, 0,0, 0);
`endif
      vecs[10] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  0,0,0,0, 0, 0, 32'h6, 0, 0,0, 0);
      vecs[11] = mk(1, 32'h20, 0, 0,  1, 32'h24, 0, 0,  0,
                    1,0,0,0, 0, 0, 32'h6, 0, 0,0, 0);
      vecs[12] = mk(0, 0, 0, 0,  1, 32'h24, 0, 0,  0,  0,0,0,0, 0, 0, 32'h20, 0, 0,0, 1);
      vecs[13] = mk(0, 0, 0, 0,  1, 32'h24, 0, 0,  32'hcafe_0001,
                    0,0,1,0, 32'hcafe_0001, 0, 32'h20, 0, 0,0, 1);
      vecs[14] = mk(0, 0, 0, 0,  1, 32'h24, 0, 0,  0,  0,1,0,0, 0, 0, 32'h20, 0, 0,0, 1);
      vecs[15] = mk(0, 0, 0, 0,  0, 0, 0, 0,  0,  0,0,0,0, 0, 0, 32'h24, 0, 0,0, 1);
      vecs[16] = mk(0, 0, 0, 0,  0, 0, 0, 0,  32'h0bad_f00d,
                    0,0,0,1, 0, 32'h0bad_f00d, 32'h24, 0, 0,0, 1);

      // Table-driven sequences on the round-robin instance
      sel = 1'b0;
      do_reset(1'b1);
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         m0_req = vecs[i].r0; m0_addr = vecs[i].a0; m0_we = vecs[i].we0; m0_wdata = vecs[i].d0;
         m1_req = vecs[i].r1; m1_addr = vecs[i].a1; m1_we = vecs[i].we1; m1_wdata = vecs[i].d1;
         mem_rdata = vecs[i].rd;
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i), {30'h0, o_g0, o_g1}, {30'h0, vecs[i].g0, vecs[i].g1});
         chk($sformatf("v%0d_rvalid", i), {30'h0, o_v0, o_v1}, {30'h0, vecs[i].v0, vecs[i].v1});
         chk($sformatf("v%0d_m0_rdata", i), o_rd0, vecs[i].rd0);
         chk($sformatf("v%0d_m1_rdata", i), o_rd1, vecs[i].rd1);
         chk($sformatf("v%0d_mem_addr", i), o_addr, vecs[i].maddr);
         chk($sformatf("v%0d_mem_wdata", i), o_wdata, vecs[i].mwdata);
         chk($sformatf("v%0d_mem_we_err", i), {30'h0, o_we, o_err}, {30'h0, vecs[i].mwe, vecs[i].err});
         chk($sformatf("v%0d_cnt", i), {16'h0, o_cnt}, {16'h0, vecs[i].cnt});
      end

      // Continuous tie, 2 reads per master: round-robin vs fixed priority
      sel = 1'b0;
      do_reset(1'b0);
      run_ties(2, 2, 1'b1, 32'h0101, 16'd3);
      sel = 1'b1;
      do_reset(1'b0);
      run_ties(2, 2, 1'b1, 32'h1100, 16'd2);
      // 20 tie cycles on a 4-bit counter must stop at 15, not wrap to 4
      do_reset(1'b0);
      run_ties(20, 20, 1'b0, 32'h0, 16'hF);

      // Reset pulsed during BUS of a write
      sel = 1'b0;
      do_reset(1'b0);
      @(posedge clk); #1;
      m1_req = 1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_we = 1;
      @(negedge clk);
      chk("rstmid_gnt", {31'h0, o_g1}, 32'h1);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("rstmid_bus_we", {31'h0, o_we}, 32'h1);
      #2 sys_rst_n = 1'b0;
      #1 chk("rstmid_we_async_drop", {31'h0, o_we}, 32'h0);
      @(posedge clk); #1;
      sys_rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rstmid_quiet%0d", k), {28'h0, o_g0, o_g1, o_v0, o_v1}, 32'h0);
         @(posedge clk); #1;
      end
      m0_req = 1; m0_addr = 32'h50; m1_req = 1; m1_addr = 32'h54;
      @(negedge clk);
      chk("rstmid_first_tie", {30'h0, o_g0, o_g1}, 32'h2);
      @(posedge clk); #1;
      drive_idle();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
